// File: rtl/logic_slice_sequencer.sv
// Bit-serial sequencer driving a 1-bit logic slice, LSB first.
// Assembles WIDTH slice results into a word behind valid/ready ports.
module logic_slice_sequencer #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic [1:0]       req_op_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_zero_o,
    output logic             busy_o,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic [1:0]       slice_sel_o,
    input  logic             slice_e_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_bit;
    logic [WIDTH-1:0] a_shift;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // The A register doubles as the result shift register: each consumed
    // A bit frees the MSB slot that receives the returned slice bit.
    assign a_shift = {slice_e_i, a_q[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid_i) state_d = RUN;
            RUN:  if (last_bit) state_d = DONE;
            DONE: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, serial shifting and result hand-off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            op_q  <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        a_q   <= req_a_i;
                        b_q   <= req_b_i;
                        op_q  <= req_op_i;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_shift;
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_bit) res_q <= a_shift;
                end
                default: ;
            endcase
        end
    end

    // Handshake flags and slice taps decoded from the state.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b0;
        slice_a_o   = 1'b0;
        slice_b_o   = 1'b0;
        unique case (state_q)
            IDLE: req_ready_o = 1'b1;
            RUN: begin
                busy_o    = 1'b1;
                slice_a_o = a_q[0];
                slice_b_o = b_q[0];
            end
            DONE: begin
                busy_o      = 1'b1;
                rsp_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign slice_sel_o  = op_q;
    assign rsp_result_o = res_q;
    assign rsp_zero_o   = rsp_valid_o && (res_q == '0);

endmodule
